// File: rtl/regfile_staged_if.sv
// rtl/regfile_staged_if.sv - write handshake, read ports and status bundle for regfile_staged
interface regfile_staged_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3,
  parameter int NUM_RD = 2
);
  logic                       clr_in;
  logic                       hold_in;
  logic                       wr_valid_in;
  logic                       wr_ready_out;
  logic [ADDR_W-1:0]          wr_addr_in;
  logic [DATA_W-1:0]          wr_data_in;
  logic [NUM_RD*ADDR_W-1:0]   rd_addr_in;
  logic [NUM_RD*DATA_W-1:0]   rd_data_out;
  logic [DATA_W-1:0]          reg0_out;
  logic                       pend_out;

  modport master (
    output clr_in, hold_in, wr_valid_in, wr_addr_in, wr_data_in, rd_addr_in,
    input  wr_ready_out, rd_data_out, reg0_out, pend_out
  );

  modport slave (
    input  clr_in, hold_in, wr_valid_in, wr_addr_in, wr_data_in, rd_addr_in,
    output wr_ready_out, rd_data_out, reg0_out, pend_out
  );
endinterface

// File: rtl/regfile_staged.sv
// rtl/regfile_staged.sv - multi-read-port register file with a one-entry staged write buffer
// Optional feature macro: REGFILE_BYPASS_EN (read ports see the staged write before it commits).
module regfile_staged #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3,
  parameter int NUM_RD = 2
) (
  input  logic              clk,
  input  logic              reset_n_in,
  regfile_staged_if.slave   bus
);

  localparam logic [ADDR_W:0] LP_DEPTH = (ADDR_W+1)'(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic              r_pend_v;
  logic [ADDR_W-1:0] r_pend_addr;
  logic [DATA_W-1:0] r_pend_data;

  logic              w_accept;
  logic              w_commit;
  logic              w_pend_in_range;
  logic [DATA_W-1:0] w_port_data [NUM_RD];

  assign bus.wr_ready_out = reset_n_in & ~bus.clr_in & (~r_pend_v | ~bus.hold_in);
  assign w_accept         = bus.wr_valid_in & bus.wr_ready_out;
  assign w_commit         = r_pend_v & ~bus.hold_in;
  assign w_pend_in_range  = ({1'b0, r_pend_addr} < LP_DEPTH);

  // Clear outranks commit and accept: a pending write is discarded, not committed.
  always_ff @(posedge clk or negedge reset_n_in) begin
    if (!reset_n_in) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_pend_v    <= 1'b0;
      r_pend_addr <= '0;
      r_pend_data <= '0;
    end else if (bus.clr_in) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_pend_v <= 1'b0;
    end else begin
      if (w_commit && w_pend_in_range) r_mem[r_pend_addr] <= r_pend_data;
      if (w_accept) begin
        r_pend_v    <= 1'b1;
        r_pend_addr <= bus.wr_addr_in;
        r_pend_data <= bus.wr_data_in;
      end else if (w_commit) begin
        r_pend_v <= 1'b0;
      end
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] w_ra;
    logic              w_in_range;
    assign w_ra       = bus.rd_addr_in[k*ADDR_W +: ADDR_W];
    assign w_in_range = ({1'b0, w_ra} < LP_DEPTH);
`ifdef REGFILE_BYPASS_EN
    assign w_port_data[k] = !w_in_range ? '0 :
                            (r_pend_v && (w_ra == r_pend_addr)) ? r_pend_data : r_mem[w_ra];
`else
    assign w_port_data[k] = w_in_range ? r_mem[w_ra] : '0;
`endif
  end

  always_comb begin
    bus.rd_data_out = '0;
    for (int k = 0; k < NUM_RD; k++) bus.rd_data_out[k*DATA_W +: DATA_W] = w_port_data[k];
  end

  assign bus.reg0_out = r_mem[0];
  assign bus.pend_out = r_pend_v;

endmodule

// File: tb/tb_regfile_staged.sv
// tb/tb_regfile_staged.sv - directed and random checks of regfile_staged against a queue-based model
module tb_regfile_staged;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 6;
  localparam int ADDR_W = 3;
  localparam int NUM_RD = 3;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n_in;
  always #5 clk = ~clk;

  regfile_staged_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD)) bus ();

  regfile_staged #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD)) dut (
    .clk        (clk),
    .reset_n_in (reset_n_in),
    .bus        (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [DATA_W-1:0] m_mem [DEPTH];
  logic [ADDR_W-1:0] q_addr [$];
  logic [DATA_W-1:0] q_data [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] exp_rd(input logic [ADDR_W-1:0] a);
    if (a >= DEPTH) return '0;
    if (BYP && q_addr.size() != 0 && q_addr[0] == a) return q_data[0];
    return m_mem[a];
  endfunction

  function automatic logic exp_ready();
    return reset_n_in && !bus.clr_in && (q_addr.size() == 0 || !bus.hold_in);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    q_addr.delete();
    q_data.delete();
  endtask

  function automatic logic [DATA_W-1:0] port(input int k);
    return bus.rd_data_out[k*DATA_W +: DATA_W];
  endfunction

  task automatic check_all(input string tag);
    chk({tag, "_ready"}, 32'(bus.wr_ready_out), 32'(exp_ready()));
    chk({tag, "_pend"}, 32'(bus.pend_out), 32'(q_addr.size() != 0));
    chk({tag, "_reg0"}, 32'(bus.reg0_out), 32'(m_mem[0]));
    for (int k = 0; k < NUM_RD; k++)
      chk($sformatf("%s_rd%0d", tag, k), 32'(port(k)),
          32'(exp_rd(bus.rd_addr_in[k*ADDR_W +: ADDR_W])));
  endtask

  task automatic drive(input logic c, input logic h, input logic wv,
                       input logic [ADDR_W-1:0] wa, input logic [DATA_W-1:0] wd,
                       input logic [NUM_RD*ADDR_W-1:0] ra);
    bus.clr_in      = c;
    bus.hold_in     = h;
    bus.wr_valid_in = wv;
    bus.wr_addr_in  = wa;
    bus.wr_data_in  = wd;
    bus.rd_addr_in  = ra;
  endtask

  // Called just after a falling edge with inputs driven; returns just after the next falling edge.
  task automatic tick(input string tag);
    logic acc;
    #1;
    check_all(tag);
    acc = bus.wr_valid_in && exp_ready();
    @(posedge clk);
    if (bus.clr_in) begin
      model_reset();
    end else begin
      if (q_addr.size() != 0 && !bus.hold_in) begin
        if (q_addr[0] < DEPTH) m_mem[q_addr[0]] = q_data[0];
        void'(q_addr.pop_front());
        void'(q_data.pop_front());
      end
      if (acc) begin
        q_addr.push_back(bus.wr_addr_in);
        q_data.push_back(bus.wr_data_in);
      end
    end
    @(negedge clk);
  endtask

  function automatic logic [NUM_RD*ADDR_W-1:0] ra3(input logic [ADDR_W-1:0] a0,
                                                   input logic [ADDR_W-1:0] a1,
                                                   input logic [ADDR_W-1:0] a2);
    return {a2, a1, a0};
  endfunction

  initial begin
    reset_n_in = 1'b0;
    model_reset();
    drive(0, 0, 0, '0, '0, ra3(0, 3, 7));
    @(negedge clk);
    @(negedge clk);
    #1;
    check_all("reset");
    chk("reset_ready0", 32'(bus.wr_ready_out), 32'd0);
    @(negedge clk);
    reset_n_in = 1'b1;

    // Single write, no hold
    drive(0, 0, 1, 3'd3, 8'hA5, ra3(3, 0, 3));
    tick("t2_acc");
    drive(0, 0, 0, 3'd0, 8'h00, ra3(3, 0, 3));
    #1;
    chk("t2_pend", 32'(bus.pend_out), 32'd1);
    chk("t2_early", 32'(port(0)), BYP ? 32'hA5 : 32'h00);
    tick("t2_commit");
    #1;
    chk("t2_mem3", 32'(port(0)), 32'hA5);
    chk("t2_pend_clr", 32'(bus.pend_out), 32'd0);

    // Commit held for four cycles
    drive(0, 0, 1, 3'd4, 8'h3C, ra3(4, 1, 3));
    tick("t3_acc");
    drive(0, 1, 1, 3'd1, 8'h99, ra3(4, 1, 3));
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t3_held_ready", 32'(bus.wr_ready_out), 32'd0);
      chk("t3_held_mem4", 32'(port(0)), BYP ? 32'h3C : 32'h00);
      tick("t3_hold");
    end
    drive(0, 0, 0, 3'd0, 8'h00, ra3(4, 1, 3));
    #1;
    chk("t3_release_ready", 32'(bus.wr_ready_out), 32'd1);
    tick("t3_commit");
    #1;
    chk("t3_mem4", 32'(port(0)), 32'h3C);
    chk("t3_mem1", 32'(port(1)), 32'h00);

    // Back-to-back writes to the same address
    drive(0, 0, 1, 3'd2, 8'h11, ra3(2, 2, 2));
    tick("t4_w1");
    drive(0, 0, 1, 3'd2, 8'h22, ra3(2, 2, 2));
    tick("t4_w2");
    #1;
    chk("t4_mid", 32'(port(0)), BYP ? 32'h22 : 32'h11);
    drive(0, 0, 0, 3'd0, 8'h00, ra3(2, 2, 2));
    tick("t4_drain");
    #1;
    chk("t4_final", 32'(port(1)), 32'h22);

    // Clear discards a pending write
    drive(0, 0, 1, 3'd5, 8'h7F, ra3(5, 3, 2));
    tick("t5_acc");
    drive(1, 0, 1, 3'd1, 8'h55, ra3(5, 3, 2));
    #1;
    chk("t5_clr_ready", 32'(bus.wr_ready_out), 32'd0);
    tick("t5_clr");
    drive(0, 0, 0, 3'd0, 8'h00, ra3(5, 3, 2));
    tick("t5_after");
    #1;
    chk("t5_mem5", 32'(port(0)), 32'h00);
    chk("t5_mem3", 32'(port(1)), 32'h00);

    // Out-of-range write address
    drive(0, 0, 1, 3'd0, 8'h42, ra3(7, 0, 6));
    tick("t6_w0");
    drive(0, 0, 1, 3'd7, 8'hFF, ra3(7, 0, 6));
    #1;
    chk("t6_ready", 32'(bus.wr_ready_out), 32'd1);
    tick("t6_acc");
    drive(0, 0, 0, 3'd0, 8'h00, ra3(7, 0, 6));
    #1;
    chk("t6_pend", 32'(bus.pend_out), 32'd1);
    tick("t6_commit");
    #1;
    chk("t6_rd7", 32'(port(0)), 32'h00);
    chk("t6_reg0", 32'(bus.reg0_out), 32'h42);

    // Asynchronous reset with a write pending
    drive(0, 0, 1, 3'd1, 8'h66, ra3(1, 0, 3));
    tick("t1_acc");
    #2;
    reset_n_in = 1'b0;
    #1;
    model_reset();
    check_all("t1_rst");
    chk("t1_pend", 32'(bus.pend_out), 32'd0);
    drive(0, 0, 0, 3'd0, 8'h00, ra3(1, 0, 3));
    @(negedge clk);
    reset_n_in = 1'b1;
    tick("t1_post");
    #1;
    chk("t1_no_stale", 32'(port(0)), 32'h00);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      drive(($urandom_range(99) < 4), ($urandom_range(99) < 30), ($urandom_range(99) < 60),
            ADDR_W'($urandom_range(7)), DATA_W'($urandom),
            (NUM_RD*ADDR_W)'($urandom));
      tick("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
